// File: rtl/dcache_controller.sv
// ============================================================================
// Module : dcache_controller -- direct-mapped write-back/write-allocate D-cache
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_controller #(
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 5,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [255:0]      mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [255:0]      mem_data_i,
    input  logic              mem_ack_i
);

    localparam int TAG_W     = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int LINES     = 1 << INDEX_BITS;
    localparam int WORD_BITS = OFFSET_BITS - 2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0] tag_q  [LINES];
    logic [255:0]     data_q [LINES];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;

    logic [TAG_W-1:0]      w_tag;
    logic [INDEX_BITS-1:0] w_idx;
    logic [WORD_BITS-1:0]  w_word;
    logic [WORD_BITS+4:0]  w_word_lsb;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_idle_hit;
    logic                  w_store_hit;
    logic                  w_refill_done;
    logic [31:0]           w_rd_word;
    logic                  w_unused_bits;

    assign w_tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign w_idx         = cpu_addr_i[OFFSET_BITS +: INDEX_BITS];
    assign w_word        = cpu_addr_i[OFFSET_BITS-1:2];
    assign w_word_lsb    = {w_word, 5'b00000};
    assign w_unused_bits = ^cpu_addr_i[1:0];

    assign w_req         = cpu_MemRead_i | cpu_MemWrite_i;
    assign w_hit         = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign w_idle_hit    = (state_q == S_IDLE) && w_hit;
    // A simultaneous read+write is a store; the read port still shows the old word.
    assign w_store_hit   = w_idle_hit && cpu_MemWrite_i;
    assign w_refill_done = (state_q == S_REFILL) && mem_ack_i;
    assign w_rd_word     = data_q[w_idx][w_word_lsb +: 32];

    assign cpu_stall_o = w_req && !w_idle_hit;
    assign cpu_data_o  = (w_idle_hit && cpu_MemRead_i) ? w_rd_word : 32'd0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_q)
            S_IDLE: begin
                if (w_req && !w_hit) begin
                    state_d = (valid_q[w_idx] && dirty_q[w_idx]) ? S_WRITEBACK : S_REFILL;
                end
            end
            S_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[w_idx], w_idx, {OFFSET_BITS{1'b0}}};
                mem_data_o   = data_q[w_idx];
                if (mem_ack_i) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {w_tag, w_idx, {OFFSET_BITS{1'b0}}};
                if (mem_ack_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (w_refill_done) begin
            valid_q[w_idx] <= 1'b1;
            dirty_q[w_idx] <= 1'b0;
        end else if (w_store_hit) begin
            dirty_q[w_idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (w_refill_done) begin
            tag_q[w_idx]  <= w_tag;
            data_q[w_idx] <= mem_data_i;
        end else if (w_store_hit) begin
            data_q[w_idx][w_word_lsb +: 32] <= cpu_data_i;
        end
    end

endmodule

`default_nettype wire
